// File: rtl/xorshift_stream_gen.sv
// -----------------------------------------------------------------------------
// xorshift_stream_gen
//
// Parametrised xorshift pseudo-random word generator with a ready/valid output
// stream, a runtime seed load, a multi-step skip-ahead mode and a counter of
// delivered words. The output word is the state register itself, so a word is
// offered with zero latency and never depends combinationally on dout_ready.
//
// Parameters
//   WIDTH   state/output width, 32 or 64 only
//   SEED    reset and fallback seed (a zero SEED is treated as 1)
//   SKIP_W  width of skip_count
//   CNT_W   width of the delivered-word counter
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   seed_valid  in   load seed_data this cycle (highest priority)
//   seed_data   in   new seed value; zero is replaced by the fallback seed
//   skip_req    in   start a skip-ahead of skip_count steps (RUN only)
//   skip_count  in   number of steps to skip; zero makes skip_req a no-op
//   dout        out  current state word
//   dout_valid  out  dout is offered (RUN)
//   dout_ready  in   consumer accepts dout
//   busy        out  skip in progress (SKIP)
//   seed_err    out  one-cycle pulse after a zero seed was replaced
//   word_cnt    out  accepted words, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module xorshift_stream_gen #(
  parameter int unsigned       WIDTH  = 32,
  parameter logic [WIDTH-1:0]  SEED   = WIDTH'(1),
  parameter int unsigned       SKIP_W = 8,
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              seed_valid,
  input  logic [WIDTH-1:0]  seed_data,
  input  logic              skip_req,
  input  logic [SKIP_W-1:0] skip_count,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              seed_err,
  output logic [CNT_W-1:0]  word_cnt
);

  // Only the two published shift triplets exist; anything else is refused.
  if ((WIDTH != 32'd32) && (WIDTH != 32'd64)) begin : g_bad_width
    $error("xorshift_stream_gen: WIDTH must be 32 or 64");
  end

  // A zero state is a fixed point of xorshift, so a zero SEED is replaced.
  localparam logic [WIDTH-1:0]  SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SKIP_W-1:0] REM_ONE  = {{(SKIP_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_SKIP = 1'b1
  } fsm_e;

  // One xorshift step; shifts are logical and drop bits leaving the word.
  function automatic logic [WIDTH-1:0] xs_step(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    y = x;
    if (WIDTH == 32'd64) begin
      y = y ^ (y << 6'd13);
      y = y ^ (y >> 6'd7);
      y = y ^ (y << 6'd17);
    end else begin
      y = y ^ (y << 6'd13);
      y = y ^ (y >> 6'd17);
      y = y ^ (y << 6'd5);
    end
    return y;
  endfunction

  fsm_e              fsm_q, fsm_d;
  logic [WIDTH-1:0]  state_q, state_d;
  logic [SKIP_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              seed_err_q, seed_err_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  run_state_s;
  logic              handshake_s;

  // Handshake only exists while the word is offered.
  assign handshake_s = valid_q & dout_ready;

  // State advanced by an accepted word in RUN (unchanged otherwise).
  always_comb begin
    run_state_s = state_q;
    if (handshake_s) begin
      run_state_s = xs_step(state_q);
    end else begin
      run_state_s = state_q;
    end
  end

  // Next-state logic: seed load beats everything, then the RUN/SKIP machine.
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    seed_err_d = 1'b0;

    if (seed_valid) begin
      // Seed load cancels any skip and drops a same-cycle handshake or skip.
      fsm_d = ST_RUN;
      rem_d = '0;
      if (seed_data == '0) begin
        state_d    = SEED_EFF;
        seed_err_d = 1'b1;
      end else begin
        state_d    = seed_data;
        seed_err_d = 1'b0;
      end
    end else begin
      case (fsm_q)
        ST_RUN: begin
          state_d = run_state_s;
          if (handshake_s) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
          // A skip launched with a handshake starts from the stepped state.
          if (skip_req && (skip_count != '0)) begin
            fsm_d = ST_SKIP;
            rem_d = skip_count;
          end else begin
            fsm_d = ST_RUN;
            rem_d = rem_q;
          end
        end
        ST_SKIP: begin
          state_d = xs_step(state_q);
          if (rem_q == REM_ONE) begin
            // Last skip step: the word is offered again on the next cycle.
            fsm_d = ST_RUN;
            rem_d = '0;
          end else begin
            fsm_d = ST_SKIP;
            rem_d = rem_q - REM_ONE;
          end
        end
        default: begin
          fsm_d   = ST_RUN;
          rem_d   = '0;
          state_d = SEED_EFF;
        end
      endcase
    end
  end

  // Output flags are registered versions of the next FSM state.
  always_comb begin
    valid_d = 1'b1;
    busy_d  = 1'b0;
    case (fsm_d)
      ST_RUN: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end
      ST_SKIP: begin
        valid_d = 1'b0;
        busy_d  = 1'b1;
      end
      default: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, skip counter, word counter and output flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q      <= ST_RUN;
      state_q    <= SEED_EFF;
      rem_q      <= '0;
      cnt_q      <= '0;
      seed_err_q <= 1'b0;
      valid_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      seed_err_q <= seed_err_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign dout       = state_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign seed_err   = seed_err_q;
  assign word_cnt   = cnt_q;

`ifdef FORMAL
  a_state_nonzero: assert property (@(posedge clock) disable iff (!reset)
    state_q != '0);
  a_busy_is_skip: assert property (@(posedge clock) disable iff (!reset)
    busy_q == (fsm_q == ST_SKIP));
  a_valid_busy_excl: assert property (@(posedge clock) disable iff (!reset)
    !(valid_q && busy_q));
`endif

endmodule

// File: tb/tb_xorshift_stream_gen.sv
module tb_xorshift_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // index 0 drives the 32-bit instance, index 1 the 64-bit instance
  logic        sv  [2];
  logic [63:0] sd  [2];
  logic        sk  [2];
  logic [7:0]  sc  [2];
  logic        rdy [2];

  logic [31:0] dout32;
  logic [63:0] dout64;
  logic        v32, v64, b32, b64, e32, e64;
  logic [15:0] c32;
  logic [3:0]  c64;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  xorshift_stream_gen #(.WIDTH(32), .SEED(32'd1), .SKIP_W(8), .CNT_W(16)) dut32 (
    .clock(clk), .reset(rst_n),
    .seed_valid(sv[0]), .seed_data(sd[0][31:0]),
    .skip_req(sk[0]), .skip_count(sc[0]),
    .dout(dout32), .dout_valid(v32), .dout_ready(rdy[0]),
    .busy(b32), .seed_err(e32), .word_cnt(c32)
  );

  xorshift_stream_gen #(.WIDTH(64), .SEED(64'd1), .SKIP_W(8), .CNT_W(4)) dut64 (
    .clock(clk), .reset(rst_n),
    .seed_valid(sv[1]), .seed_data(sd[1]),
    .skip_req(sk[1]), .skip_count(sc[1]),
    .dout(dout64), .dout_valid(v64), .dout_ready(rdy[1]),
    .busy(b64), .seed_err(e64), .word_cnt(c64)
  );

  // ---------------- behavioural model ----------------
  bit [63:0] m_state [2];
  int        m_skip  [2];   // skip steps still to run (0 = offering words)
  int        m_cnt   [2];
  bit        m_err   [2];

  // xorshift written as multiply/divide by powers of two
  function automatic bit [63:0] mstep(input bit [63:0] x, input int i);
    bit [31:0] y32;
    bit [63:0] y64;
    if (i == 0) begin
      y32 = x[31:0];
      y32 = y32 ^ (y32 * 32'd8192);
      y32 = y32 ^ (y32 / 32'd131072);
      y32 = y32 ^ (y32 * 32'd32);
      return {32'd0, y32};
    end
    y64 = x;
    y64 = y64 ^ (y64 * 64'd8192);
    y64 = y64 ^ (y64 / 64'd128);
    y64 = y64 ^ (y64 * 64'd131072);
    return y64;
  endfunction

  function automatic int cnt_mod(input int i);
    return (i == 0) ? 65536 : 16;
  endfunction

  function automatic bit [63:0] seed_of(input int i);
    return (i == 0) ? {32'd0, sd[0][31:0]} : sd[1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_state[i] <= 64'd1;
        m_skip[i]  <= 0;
        m_cnt[i]   <= 0;
        m_err[i]   <= 1'b0;
      end else if (sv[i]) begin
        m_skip[i]  <= 0;
        m_err[i]   <= (seed_of(i) == 64'd0);
        m_state[i] <= (seed_of(i) == 64'd0) ? 64'd1 : seed_of(i);
      end else if (m_skip[i] > 0) begin
        m_err[i]   <= 1'b0;
        m_state[i] <= mstep(m_state[i], i);
        m_skip[i]  <= m_skip[i] - 1;
      end else begin
        m_err[i] <= 1'b0;
        if (rdy[i]) begin
          m_state[i] <= mstep(m_state[i], i);
          m_cnt[i]   <= (m_cnt[i] + 1) % cnt_mod(i);
        end
        if (sk[i] && sc[i] != 8'd0) m_skip[i] <= int'(sc[i]);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: DUT against model every cycle, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("dout32",  {32'd0, dout32}, m_state[0]);
      chk("valid32", 64'(v32), 64'(m_skip[0] == 0));
      chk("busy32",  64'(b32), 64'(m_skip[0] > 0));
      chk("err32",   64'(e32), 64'(m_err[0]));
      chk("cnt32",   64'(c32), 64'(m_cnt[0]));
      chk("dout64",  dout64, m_state[1]);
      chk("valid64", 64'(v64), 64'(m_skip[1] == 0));
      chk("busy64",  64'(b64), 64'(m_skip[1] > 0));
      chk("err64",   64'(e64), 64'(m_err[1]));
      chk("cnt64",   64'(c64), 64'(m_cnt[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus + hand-computed expectations ----------------
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0; sd[i] = 64'd0; sk[i] = 1'b0; sc[i] = 8'd0; rdy[i] = 1'b0;
    end
    repeat (2) tick();
    cmp_en = 1'b1;
    chk("rst_dout32", {32'd0, dout32}, 64'd1);
    chk("rst_valid",  64'(v32), 64'd1);
    chk("rst_busy",   64'(b32), 64'd0);
    chk("rst_err",    64'(e32), 64'd0);
    chk("rst_cnt",    64'(c32), 64'd0);
    chk("rst_dout64", dout64, 64'd1);
    rst_n = 1'b1;

    // three accepted words from seed 1
    rdy[0] = 1'b1;
    tick(); chk("seq1", {32'd0, dout32}, 64'd270369);
    tick(); chk("seq2", {32'd0, dout32}, 64'd67634689);
    tick(); chk("seq3", {32'd0, dout32}, 64'd2647435461);
    chk("seq_cnt", 64'(c32), 64'd3);
    rdy[0] = 1'b0;

    // asynchronous reset mid-cycle
    rst_n = 1'b0; #1;
    chk("arst_dout", {32'd0, dout32}, 64'd1);
    chk("arst_cnt",  64'(c32), 64'd0);
    tick(); rst_n = 1'b1;

    // backpressure holds the word
    repeat (5) tick();
    chk("hold_dout",  {32'd0, dout32}, 64'd1);
    chk("hold_valid", 64'(v32), 64'd1);
    chk("hold_cnt",   64'(c32), 64'd0);
    rdy[0] = 1'b1; tick(); rdy[0] = 1'b0;
    chk("one_dout", {32'd0, dout32}, 64'd270369);
    chk("one_cnt",  64'(c32), 64'd1);

    // skip of 3 from state 1
    sv[0] = 1'b1; sd[0] = 64'd1; tick(); sv[0] = 1'b0;
    sk[0] = 1'b1; sc[0] = 8'd3; tick(); sk[0] = 1'b0; sc[0] = 8'd0;
    rdy[0] = 1'b1;
    chk("skip_b1", 64'(b32), 64'd1);
    chk("skip_v1", 64'(v32), 64'd0);
    tick(); chk("skip_b2", 64'(b32), 64'd1);
    tick(); chk("skip_b3", 64'(b32), 64'd1);
    tick(); chk("skip_end_b", 64'(b32), 64'd0);
    chk("skip_end_v",   64'(v32), 64'd1);
    chk("skip_end_d",   {32'd0, dout32}, 64'd2647435461);
    chk("skip_end_cnt", 64'(c32), 64'd1);
    rdy[0] = 1'b0;

    // zero seed with a same-cycle handshake
    rdy[0] = 1'b1; sv[0] = 1'b1; sd[0] = 64'd0; tick(); sv[0] = 1'b0; rdy[0] = 1'b0;
    chk("zseed_dout", {32'd0, dout32}, 64'd1);
    chk("zseed_err",  64'(e32), 64'd1);
    chk("zseed_cnt",  64'(c32), 64'd1);
    tick(); chk("zseed_err_off", 64'(e32), 64'd0);

    // seed load during skip
    sk[0] = 1'b1; sc[0] = 8'd10; tick(); sk[0] = 1'b0; tick();
    sv[0] = 1'b1; sd[0] = 64'h0000_0000_DEAD_BEEF; tick(); sv[0] = 1'b0;
    chk("sskip_busy",  64'(b32), 64'd0);
    chk("sskip_valid", 64'(v32), 64'd1);
    chk("sskip_dout",  {32'd0, dout32}, 64'h0000_0000_DEAD_BEEF);

    // handshake and skip in the same cycle (model checks the result)
    rdy[0] = 1'b1; sk[0] = 1'b1; sc[0] = 8'd2; tick();
    rdy[0] = 1'b0; sk[0] = 1'b0; sc[0] = 8'd0;
    repeat (3) tick();

    // reset taken low mid-skip
    sk[0] = 1'b1; sc[0] = 8'd50; tick(); sk[0] = 1'b0; tick(); tick();
    chk("mskip_busy", 64'(b32), 64'd1);
    rst_n = 1'b0; #1;
    chk("mrst_busy",  64'(b32), 64'd0);
    chk("mrst_valid", 64'(v32), 64'd1);
    chk("mrst_dout",  {32'd0, dout32}, 64'd1);
    chk("mrst_cnt",   64'(c32), 64'd0);
    chk("mrst_d64",   dout64, 64'd1);
    tick(); rst_n = 1'b1;

    // 64-bit step and counter wrap (CNT_W=4)
    rdy[1] = 1'b1; tick();
    chk("step64", dout64, 64'h0000_0000_4082_2041);
    repeat (16) tick();
    rdy[1] = 1'b0;
    chk("wrap64", 64'(c64), 64'd1);

    // randomized traffic on both instances
    repeat (3000) begin
      for (int i = 0; i < 2; i++) begin
        sv[i]  = ($urandom_range(31) == 0);
        sd[i]  = ($urandom_range(3) == 0) ? 64'd0 : {$urandom, $urandom};
        if (i == 0) sd[i][63:32] = 32'd0;
        sk[i]  = ($urandom_range(15) == 0);
        sc[i]  = 8'($urandom_range(7));
        rdy[i] = ($urandom_range(1) == 1);
      end
      rst_n = ($urandom_range(499) != 0);
      tick();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0; sk[i] = 1'b0; rdy[i] = 1'b0;
    end
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
